// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vending_pkg
// Description : Shared types and constants for the vending change path.
// Revision    : 1.0 - initial release
// ============================================================================
package vending_pkg;

    localparam int AMT_W    = 5;

    localparam int DENOM_5  = 5;
    localparam int DENOM_10 = 10;
    localparam int DENOM_20 = 20;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_5    = 2'd1;
    localparam logic [1:0] COIN_10   = 2'd2;
    localparam logic [1:0] COIN_20   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PICK  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } disp_state_t;

endpackage
`default_nettype wire

// File: rtl/coin_inventory.sv
`default_nettype none
// ============================================================================
// Module      : coin_inventory
// Description : Per-denomination coin counters, decrement-on-eject, reload.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_inventory #(
    parameter int CNT_W       = 4,
    parameter int INIT_CNT_20 = 4,
    parameter int INIT_CNT_10 = 8,
    parameter int INIT_CNT_5  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             refill,
    input  logic [1:0]       dec_sel,
    output logic [CNT_W-1:0] cnt_20,
    output logic [CNT_W-1:0] cnt_10,
    output logic [CNT_W-1:0] cnt_5
);
    import vending_pkg::*;

    localparam logic [CNT_W-1:0] c_init_20 = CNT_W'(INIT_CNT_20);
    localparam logic [CNT_W-1:0] c_init_10 = CNT_W'(INIT_CNT_10);
    localparam logic [CNT_W-1:0] c_init_5  = CNT_W'(INIT_CNT_5);

    // Counters stop at zero even if a decrement is requested on an empty bin.
    always_ff @(posedge clk) begin
        if (reset || refill) begin
            cnt_20 <= c_init_20;
            cnt_10 <= c_init_10;
            cnt_5  <= c_init_5;
        end else begin
            if (dec_sel == COIN_20 && cnt_20 != '0) cnt_20 <= cnt_20 - 1'b1;
            if (dec_sel == COIN_10 && cnt_10 != '0) cnt_10 <= cnt_10 - 1'b1;
            if (dec_sel == COIN_5  && cnt_5  != '0) cnt_5  <= cnt_5  - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : change_dispenser
// Description : Greedy 20/10/5 change sequencer driving a coin hopper.
// Revision    : 1.0 - initial release
// ============================================================================
module change_dispenser #(
    parameter int AMT_W       = vending_pkg::AMT_W,
    parameter int CNT_W       = 4,
    parameter int INIT_CNT_20 = 4,
    parameter int INIT_CNT_10 = 8,
    parameter int INIT_CNT_5  = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] change_amt,
    input  logic             refill,
    output logic             coin_req,
    output logic [1:0]       coin_sel,
    input  logic             coin_ack,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] short_amt,
    output logic             fault,
    output logic [CNT_W-1:0] cnt_20,
    output logic [CNT_W-1:0] cnt_10,
    output logic [CNT_W-1:0] cnt_5
);
    import vending_pkg::*;

    localparam int               c_tmr_w    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(ACK_TIMEOUT - 1);
    localparam logic [AMT_W-1:0] c_d20      = AMT_W'(DENOM_20);
    localparam logic [AMT_W-1:0] c_d10      = AMT_W'(DENOM_10);
    localparam logic [AMT_W-1:0] c_d5       = AMT_W'(DENOM_5);

    disp_state_t        r_state;
    logic [AMT_W-1:0]   r_remaining;
    logic [c_tmr_w-1:0] r_timer;

    logic [1:0]         w_pick_sel;
    logic [AMT_W-1:0]   w_issue_denom;
    logic [1:0]         w_dec_sel;
    logic               w_refill;

    assign w_refill  = refill && (r_state == ST_IDLE);
    assign w_dec_sel = (r_state == ST_ISSUE && coin_ack) ? coin_sel : COIN_NONE;

    coin_inventory #(
        .CNT_W       (CNT_W),
        .INIT_CNT_20 (INIT_CNT_20),
        .INIT_CNT_10 (INIT_CNT_10),
        .INIT_CNT_5  (INIT_CNT_5)
    ) u_inventory (
        .clk     (clk),
        .reset   (reset),
        .refill  (w_refill),
        .dec_sel (w_dec_sel),
        .cnt_20  (cnt_20),
        .cnt_10  (cnt_10),
        .cnt_5   (cnt_5)
    );

    always_comb begin
        w_pick_sel = COIN_NONE;
        if (r_remaining >= c_d20 && cnt_20 != '0)
            w_pick_sel = COIN_20;
        else if (r_remaining >= c_d10 && cnt_10 != '0)
            w_pick_sel = COIN_10;
        else if (r_remaining >= c_d5 && cnt_5 != '0)
            w_pick_sel = COIN_5;
    end

    always_comb begin
        case (coin_sel)
            COIN_20: w_issue_denom = c_d20;
            COIN_10: w_issue_denom = c_d10;
            COIN_5:  w_issue_denom = c_d5;
            default: w_issue_denom = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_timer     <= '0;
            coin_req    <= 1'b0;
            coin_sel    <= COIN_NONE;
            busy        <= 1'b0;
            done        <= 1'b0;
            short_amt   <= '0;
            fault       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_remaining <= change_amt;
                        short_amt   <= '0;
                        fault       <= 1'b0;
                        busy        <= 1'b1;
                        r_state     <= ST_PICK;
                    end
                end
                ST_PICK: begin
                    if (w_pick_sel != COIN_NONE) begin
                        coin_sel <= w_pick_sel;
                        coin_req <= 1'b1;
                        r_timer  <= '0;
                        r_state  <= ST_ISSUE;
                    end else begin
                        short_amt <= r_remaining;
                        done      <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_ISSUE: begin
                    // An ack in the last waiting cycle still wins over the timeout.
                    if (coin_ack) begin
                        r_remaining <= r_remaining - w_issue_denom;
                        coin_req    <= 1'b0;
                        coin_sel    <= COIN_NONE;
                        r_timer     <= '0;
                        r_state     <= ST_PICK;
                    end else if (r_timer == c_tmr_last) begin
                        fault     <= 1'b1;
                        short_amt <= r_remaining;
                        coin_req  <= 1'b0;
                        coin_sel  <= COIN_NONE;
                        r_timer   <= '0;
                        done      <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : tb_change_dispenser
// Description : Self-checking bench for change_dispenser with a greedy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

    localparam int AMT_W       = 5;
    localparam int CNT_W       = 4;
    localparam int INIT_CNT_20 = 4;
    localparam int INIT_CNT_10 = 8;
    localparam int INIT_CNT_5  = 8;
    localparam int ACK_TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [AMT_W-1:0] change_amt = '0;
    logic             refill = 1'b0;
    logic             coin_req;
    logic [1:0]       coin_sel;
    logic             coin_ack = 1'b0;
    logic             busy;
    logic             done;
    logic [AMT_W-1:0] short_amt;
    logic             fault;
    logic [CNT_W-1:0] cnt_20;
    logic [CNT_W-1:0] cnt_10;
    logic [CNT_W-1:0] cnt_5;

    change_dispenser #(
        .AMT_W       (AMT_W),
        .CNT_W       (CNT_W),
        .INIT_CNT_20 (INIT_CNT_20),
        .INIT_CNT_10 (INIT_CNT_10),
        .INIT_CNT_5  (INIT_CNT_5),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .change_amt (change_amt),
        .refill     (refill),
        .coin_req   (coin_req),
        .coin_sel   (coin_sel),
        .coin_ack   (coin_ack),
        .busy       (busy),
        .done       (done),
        .short_amt  (short_amt),
        .fault      (fault),
        .cnt_20     (cnt_20),
        .cnt_10     (cnt_10),
        .cnt_5      (cnt_5)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference inventory: index 0 = 5-coins, 1 = 10-coins, 2 = 20-coins.
    int m_inv[3];
    int exp_code, exp_short, exp_done, exp_fault, exp_ncoin;
    int obs_code, obs_short, obs_done_cyc, obs_req_cycles, obs_ncoin;
    bit obs_fault, obs_busy_gap, obs_busy_after, obs_sel_unstable;

    task automatic model_reset();
        m_inv[0] = INIT_CNT_5;
        m_inv[1] = INIT_CNT_10;
        m_inv[2] = INIT_CNT_20;
    endtask

    // Greedy change from the rules: largest affordable, in-stock coin first.
    // Coin sequence is folded into exp_code as base-4 digits behind a leading 1.
    task automatic model_txn(input int amt, input int delay, input bit with_refill);
        int val[3];
        int rem, d;
        val[0] = 5; val[1] = 10; val[2] = 20;
        if (with_refill) model_reset();
        rem = amt; exp_code = 1; exp_fault = 0; exp_done = 2; exp_ncoin = 0;
        while (1) begin
            d = -1;
            for (int i = 2; i >= 0; i--)
                if (d < 0 && rem >= val[i] && m_inv[i] > 0) d = i;
            if (d < 0) break;
            exp_code = exp_code * 4 + (d + 1);
            exp_ncoin++;
            if (delay < 0) begin
                exp_fault = 1;
                exp_done += ACK_TIMEOUT;
                break;
            end
            rem -= val[d];
            m_inv[d]--;
            exp_done += 2 + delay;
        end
        exp_short = rem;
    endtask

    // Hopper emulation: ack after `delay` waiting cycles (negative = never).
    // With noise set, stray acks, starts and refills are thrown in.
    task automatic drive_txn(input int amt, input int delay, input bit with_refill, input bit noise);
        int cyc, wait_cnt;
        bit in_req;
        logic [1:0] held_sel;
        obs_code = 1; obs_ncoin = 0; obs_done_cyc = -1; obs_short = -1; obs_fault = 1'b0;
        obs_req_cycles = 0; obs_busy_gap = 1'b0; obs_sel_unstable = 1'b0;
        held_sel = 2'd0;
        @(negedge clk);
        start = 1'b1; change_amt = AMT_W'(amt); refill = with_refill;
        @(negedge clk);
        start = 1'b0; refill = 1'b0; change_amt = AMT_W'($urandom);
        cyc = 1; wait_cnt = 0; in_req = 1'b0;
        while (cyc < 100) begin
            if (!busy) obs_busy_gap = 1'b1;
            if (done) begin
                obs_done_cyc = cyc;
                obs_short    = int'(short_amt);
                obs_fault    = fault;
                break;
            end
            if (coin_req) begin
                if (!in_req) begin
                    obs_code = obs_code * 4 + int'(coin_sel);
                    obs_ncoin++;
                    held_sel = coin_sel;
                end else if (coin_sel !== held_sel) begin
                    obs_sel_unstable = 1'b1;
                end
                in_req = 1'b1;
                obs_req_cycles++;
                if (delay >= 0 && wait_cnt >= delay) begin
                    coin_ack = 1'b1; wait_cnt = 0;
                end else begin
                    coin_ack = 1'b0; wait_cnt++;
                end
            end else begin
                in_req = 1'b0;
                coin_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (noise) begin
                start  = 1'($urandom_range(0, 1));
                refill = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
        end
        coin_ack = 1'b0; start = 1'b0; refill = 1'b0;
        @(negedge clk);
        obs_busy_after = busy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (coin_req !== 1'b0) begin n_bad++; $display("FAIL reset_coin_req got=%b exp=0", coin_req); end
        n_cmp++; if (coin_sel !== 2'd0) begin n_bad++; $display("FAIL reset_coin_sel got=%0d exp=0", coin_sel); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (short_amt !== '0) begin n_bad++; $display("FAIL reset_short got=%0d exp=0", short_amt); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
        n_cmp++; if (cnt_20 !== CNT_W'(INIT_CNT_20) || cnt_10 !== CNT_W'(INIT_CNT_10) || cnt_5 !== CNT_W'(INIT_CNT_5)) begin
            n_bad++; $display("FAIL reset_inventory got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                              cnt_20, cnt_10, cnt_5, INIT_CNT_20, INIT_CNT_10, INIT_CNT_5);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_greedy_25();
        model_txn(25, 0, 1'b0);
        drive_txn(25, 0, 1'b0, 1'b0);
        n_cmp++; if (obs_code !== 29) begin n_bad++; $display("FAIL g25_coin_seq got=%0h exp=%0h", obs_code, 29); end
        n_cmp++; if (obs_done_cyc !== 6) begin n_bad++; $display("FAIL g25_done_cycle got=%0d exp=6", obs_done_cyc); end
        n_cmp++; if (obs_short !== 0 || obs_fault !== 1'b0) begin n_bad++; $display("FAIL g25_short_fault got=%0d/%b exp=0/0", obs_short, obs_fault); end
        n_cmp++; if (cnt_20 !== 4'd3 || cnt_5 !== 4'd7 || cnt_10 !== 4'd8) begin n_bad++; $display("FAIL g25_inventory got=%0d/%0d/%0d exp=3/8/7", cnt_20, cnt_10, cnt_5); end
        n_cmp++; if (obs_busy_gap || obs_busy_after) begin n_bad++; $display("FAIL g25_busy gap=%b after=%b exp=0/0", obs_busy_gap, obs_busy_after); end
    endtask

    task automatic test_no_twenty();
        int c10_before;
        while (m_inv[2] > 0) begin
            model_txn(20, 0, 1'b0);
            drive_txn(20, 0, 1'b0, 1'b0);
        end
        n_cmp++; if (cnt_20 !== 4'd0) begin n_bad++; $display("FAIL no20_cnt20 got=%0d exp=0", cnt_20); end
        c10_before = m_inv[1];
        model_txn(30, 0, 1'b0);
        drive_txn(30, 0, 1'b0, 1'b0);
        n_cmp++; if (obs_code !== exp_code || obs_ncoin !== 3) begin n_bad++; $display("FAIL no20_coin_seq got=%0h exp=%0h", obs_code, exp_code); end
        n_cmp++; if (obs_short !== 0) begin n_bad++; $display("FAIL no20_short got=%0d exp=0", obs_short); end
        n_cmp++; if (int'(cnt_10) !== c10_before - 3) begin n_bad++; $display("FAIL no20_cnt10 got=%0d exp=%0d", cnt_10, c10_before - 3); end
    endtask

    task automatic test_short_stock();
        while (m_inv[1] > 0) begin
            model_txn(10, 0, 1'b0);
            drive_txn(10, 0, 1'b0, 1'b0);
        end
        while (m_inv[0] > 1) begin
            model_txn(5, 0, 1'b0);
            drive_txn(5, 0, 1'b0, 1'b0);
        end
        n_cmp++; if (cnt_10 !== 4'd0 || cnt_5 !== 4'd1) begin n_bad++; $display("FAIL stock_drain got=%0d/%0d exp=0/1", cnt_10, cnt_5); end
        model_txn(15, 1, 1'b0);
        drive_txn(15, 1, 1'b0, 1'b0);
        n_cmp++; if (obs_code !== 5) begin n_bad++; $display("FAIL stock_coin_seq got=%0h exp=5", obs_code); end
        n_cmp++; if (obs_short !== 10 || obs_fault !== 1'b0) begin n_bad++; $display("FAIL stock_short_fault got=%0d/%b exp=10/0", obs_short, obs_fault); end
        n_cmp++; if (cnt_5 !== 4'd0) begin n_bad++; $display("FAIL stock_cnt5 got=%0d exp=0", cnt_5); end
    endtask

    task automatic test_refill_with_start();
        model_txn(20, 0, 1'b1);
        drive_txn(20, 0, 1'b1, 1'b0);
        n_cmp++; if (obs_code !== 7) begin n_bad++; $display("FAIL refill_start_seq got=%0h exp=7", obs_code); end
        n_cmp++; if (cnt_20 !== CNT_W'(INIT_CNT_20 - 1) || cnt_10 !== CNT_W'(INIT_CNT_10)) begin
            n_bad++; $display("FAIL refill_start_inventory got=%0d/%0d exp=%0d/%0d", cnt_20, cnt_10, INIT_CNT_20 - 1, INIT_CNT_10);
        end
    endtask

    task automatic test_odd_and_zero();
        model_txn(7, 0, 1'b0);
        drive_txn(7, 0, 1'b0, 1'b0);
        n_cmp++; if (obs_code !== 5 || obs_short !== 2) begin n_bad++; $display("FAIL odd7 got=seq %0h short %0d exp=seq 5 short 2", obs_code, obs_short); end
        model_txn(0, 0, 1'b0);
        drive_txn(0, 0, 1'b0, 1'b0);
        n_cmp++; if (obs_req_cycles !== 0 || obs_done_cyc !== 2) begin n_bad++; $display("FAIL zero_amt got=req %0d done %0d exp=req 0 done 2", obs_req_cycles, obs_done_cyc); end
        n_cmp++; if (obs_short !== 0) begin n_bad++; $display("FAIL zero_short got=%0d exp=0", obs_short); end
    endtask

    task automatic test_timeout();
        model_txn(25, -1, 1'b0);
        drive_txn(25, -1, 1'b0, 1'b0);
        n_cmp++; if (obs_req_cycles !== ACK_TIMEOUT) begin n_bad++; $display("FAIL tmo_req_cycles got=%0d exp=%0d", obs_req_cycles, ACK_TIMEOUT); end
        n_cmp++; if (obs_fault !== 1'b1 || obs_short !== 25) begin n_bad++; $display("FAIL tmo_fault_short got=%b/%0d exp=1/25", obs_fault, obs_short); end
        n_cmp++; if (obs_done_cyc !== exp_done || obs_sel_unstable) begin n_bad++; $display("FAIL tmo_done got=%0d unstable=%b exp=%0d", obs_done_cyc, obs_sel_unstable, exp_done); end
        n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL tmo_fault_held got=%b exp=1", fault); end
        n_cmp++; if (int'(cnt_20) !== m_inv[2]) begin n_bad++; $display("FAIL tmo_cnt20 got=%0d exp=%0d", cnt_20, m_inv[2]); end
        model_txn(10, 0, 1'b0);
        drive_txn(10, 0, 1'b0, 1'b0);
        n_cmp++; if (obs_fault !== 1'b0 || obs_code !== exp_code) begin n_bad++; $display("FAIL tmo_recover got=fault %b seq %0h exp=fault 0 seq %0h", obs_fault, obs_code, exp_code); end
    endtask

    task automatic test_busy_ignore();
        model_txn(30, 2, 1'b0);
        drive_txn(30, 2, 1'b0, 1'b1);
        n_cmp++; if (obs_code !== exp_code || obs_short !== exp_short) begin n_bad++; $display("FAIL busy_noise_seq got=%0h/%0d exp=%0h/%0d", obs_code, obs_short, exp_code, exp_short); end
        n_cmp++; if (int'(cnt_20) !== m_inv[2] || int'(cnt_10) !== m_inv[1] || int'(cnt_5) !== m_inv[0]) begin
            n_bad++; $display("FAIL busy_noise_inventory got=%0d/%0d/%0d exp=%0d/%0d/%0d", cnt_20, cnt_10, cnt_5, m_inv[2], m_inv[1], m_inv[0]);
        end
        n_cmp++; if (obs_done_cyc !== exp_done || obs_sel_unstable) begin n_bad++; $display("FAIL busy_noise_done got=%0d unstable=%b exp=%0d", obs_done_cyc, obs_sel_unstable, exp_done); end
    endtask

    task automatic test_reset_mid();
        int cyc;
        do_reset();
        @(negedge clk);
        start = 1'b1; change_amt = 5'd25;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!coin_req && cyc < 20) begin @(negedge clk); cyc++; end
        coin_ack = 1'b1;
        @(negedge clk);
        coin_ack = 1'b0;
        cyc = 0;
        while (!coin_req && cyc < 20) begin @(negedge clk); cyc++; end
        n_cmp++; if (coin_req !== 1'b1 || cnt_20 !== CNT_W'(INIT_CNT_20 - 1)) begin
            n_bad++; $display("FAIL mid_pre_reset got=req %b cnt20 %0d exp=req 1 cnt20 %0d", coin_req, cnt_20, INIT_CNT_20 - 1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_cmp++; if (coin_req !== 1'b0 || coin_sel !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0 || short_amt !== '0) begin
            n_bad++; $display("FAIL mid_reset_outputs got=req %b sel %0d busy %b done %b fault %b short %0d exp=all 0",
                              coin_req, coin_sel, busy, done, fault, short_amt);
        end
        n_cmp++; if (cnt_20 !== CNT_W'(INIT_CNT_20) || cnt_10 !== CNT_W'(INIT_CNT_10) || cnt_5 !== CNT_W'(INIT_CNT_5)) begin
            n_bad++; $display("FAIL mid_reset_inventory got=%0d/%0d/%0d exp=%0d/%0d/%0d", cnt_20, cnt_10, cnt_5, INIT_CNT_20, INIT_CNT_10, INIT_CNT_5);
        end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_after got=done %b busy %b exp=0/0", done, busy); end
    endtask

    task automatic test_random();
        int amt, dly;
        bit rf;
        for (int t = 0; t < 24; t++) begin
            amt = $urandom_range(0, 31);
            dly = $urandom_range(0, 3);
            rf  = ($urandom_range(0, 4) == 0);
            model_txn(amt, dly, rf);
            drive_txn(amt, dly, rf, 1'b1);
            n_cmp++; if (obs_code !== exp_code || obs_short !== exp_short || obs_fault !== 1'b0) begin
                n_bad++; $display("FAIL rand_txn%0d amt=%0d got=seq %0h short %0d fault %b exp=seq %0h short %0d fault 0",
                                  t, amt, obs_code, obs_short, obs_fault, exp_code, exp_short);
            end
            n_cmp++; if (obs_done_cyc !== exp_done || obs_busy_gap || obs_busy_after || obs_sel_unstable) begin
                n_bad++; $display("FAIL rand_timing%0d got=done %0d gap %b after %b unstable %b exp=done %0d",
                                  t, obs_done_cyc, obs_busy_gap, obs_busy_after, obs_sel_unstable, exp_done);
            end
            n_cmp++; if (int'(cnt_20) !== m_inv[2] || int'(cnt_10) !== m_inv[1] || int'(cnt_5) !== m_inv[0]) begin
                n_bad++; $display("FAIL rand_inventory%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                                  t, cnt_20, cnt_10, cnt_5, m_inv[2], m_inv[1], m_inv[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_greedy_25();
        test_no_twenty();
        test_short_stock();
        test_refill_with_start();
        test_odd_and_zero();
        test_timeout();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
